usb_tx_packet_sender: RTL and testbench

USB full-speed transmit packet engine on the far side of the TX data buffer.
- On a start request it serialises SYNC, PID, payload fetched byte-by-byte from the buffer, CRC16 and EOP onto the D+/D- pair.
- Encoding: LSB-first, bit-stuffed, NRZI.
- Handles handshake packets (ACK/NAK/STALL) and data packets (DATA0/DATA1, 0-64 byte payload).

---
 rtl/usb_tx_pkg.sv | 61 ++++++
 rtl/usb_tx_crc16.sv | 27 ++
 rtl/usb_tx_packet_sender.sv | 215 +++++++++++++++++++++
 tb/tb_usb_tx_packet_sender.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/usb_tx_pkg.sv
// rtl/usb_tx_pkg.sv - shared types and constants for the USB full-speed transmit packet engine
package usb_tx_pkg;

    typedef enum logic [2:0] {
        PKT_NONE  = 3'd0,
        PKT_DATA0 = 3'd1,
        PKT_DATA1 = 3'd2,
        PKT_ACK   = 3'd3,
        PKT_NAK   = 3'd4,
        PKT_STALL = 3'd5
    } tx_packet_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_PID,
        ST_DATA,
        ST_CRC_LO,
        ST_CRC_HI,
        ST_EOP,
        ST_IDLE_J
    } tx_state_e;

    localparam logic [3:0] PID_DATA0 = 4'b0011;
    localparam logic [3:0] PID_DATA1 = 4'b1011;
    localparam logic [3:0] PID_ACK   = 4'b0010;
    localparam logic [3:0] PID_NAK   = 4'b1010;
    localparam logic [3:0] PID_STALL = 4'b1110;

    localparam logic [7:0] SYNC_BYTE = 8'h80;

    localparam logic [15:0] CRC16_INIT = 16'hFFFF;
    localparam logic [15:0] CRC16_POLY = 16'h8005;

    // {D+, D-}
    localparam logic [1:0] LINE_J   = 2'b10;
    localparam logic [1:0] LINE_K   = 2'b01;
    localparam logic [1:0] LINE_SE0 = 2'b00;

    // Bit-reverse for the LSB-first (reflected) CRC shift direction
    function automatic logic [15:0] reflect16(input logic [15:0] v);
        logic [15:0] r;
        r = '0;
        for (int i = 0; i < 16; i++) r[i] = v[15-i];
        return r;
    endfunction

    localparam logic [15:0] CRC16_POLY_REFL = reflect16(CRC16_POLY);

    function automatic logic [3:0] pid_of(input logic [2:0] pkt);
        case (pkt)
            PKT_DATA0: return PID_DATA0;
            PKT_DATA1: return PID_DATA1;
            PKT_ACK:   return PID_ACK;
            PKT_NAK:   return PID_NAK;
            PKT_STALL: return PID_STALL;
            default:   return 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/usb_tx_crc16.sv
// rtl/usb_tx_crc16.sv - serial USB CRC16, one payload bit per enable, presents the inverted remainder
module usb_tx_crc16
    import usb_tx_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        bit_en,
    input  logic        bit_in,
    output logic [15:0] crc_out
);
    logic [15:0] crc_q;
    logic        fb;

    assign fb      = crc_q[0] ^ bit_in;
    assign crc_out = ~crc_q;

    // Reflected LFSR: shift right, fold in the polynomial when feedback is set
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            crc_q <= CRC16_INIT;
        end else if (bit_en) begin
            crc_q <= (crc_q >> 1) ^ (fb ? CRC16_POLY_REFL : 16'h0000);
        end
    end

endmodule

// File: rtl/usb_tx_packet_sender.sv
// rtl/usb_tx_packet_sender.sv - USB FS TX engine: SYNC/PID/payload/CRC16/EOP, bit-stuffed NRZI; option USB_TX_PKT_CNT_EN
module usb_tx_packet_sender
    import usb_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 8,
    parameter int MAX_PAYLOAD  = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_start,
    input  logic [2:0] tx_packet,
    input  logic [6:0] buffer_occupancy,
    input  logic [7:0] tx_packet_data,
    output logic       get_tx_data,
    output logic       dplus_out,
    output logic       dminus_out,
    output logic       tx_transfer_active,
    output logic       tx_error
`ifdef USB_TX_PKT_CNT_EN
    ,
    output logic [7:0] tx_pkt_count
`endif
);
    localparam int                CNT_W      = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0]  BIT_RELOAD = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [6:0]        MAX_LEN    = 7'(MAX_PAYLOAD);

    tx_state_e        state_q;
    tx_state_e        nxt_state;
    logic [1:0]       line_q;
    logic             nrzi_j;
    logic [CNT_W-1:0] clk_cnt;
    logic [2:0]       bit_idx;
    logic [2:0]       stuff_cnt;
    logic [7:0]       shreg;
    logic [7:0]       new_byte;
    logic [7:0]       nxt_byte;
    logic             cap_pending;
    logic [6:0]       byte_cnt;
    logic [6:0]       length;
    logic [3:0]       pid;
    logic             is_data;
    logic [15:0]      crc_out;

    logic boundary, serial, stuff_now, byte_end, last_byte, fetch_due;
    logic emit_val, enter_eop, line_emit, crc_en, toggle, nrzi_next;
    logic valid_pkt, accept;

    assign dplus_out  = line_q[1];
    assign dminus_out = line_q[0];

    assign boundary  = (state_q != ST_IDLE) && (clk_cnt == '0);
    assign serial    = state_q inside {ST_SYNC, ST_PID, ST_DATA, ST_CRC_LO, ST_CRC_HI};
    assign stuff_now = boundary && serial && (stuff_cnt == 3'd6);
    assign byte_end  = (bit_idx == 3'd7);
    assign last_byte = ((byte_cnt + 7'd1) == length);
    assign fetch_due = ((state_q == ST_PID) && is_data && (length != 7'd0)) ||
                       ((state_q == ST_DATA) && !last_byte);
    // With two clocks per bit the fetched byte lands on the same edge it is needed
    assign new_byte  = cap_pending ? tx_packet_data : shreg;
    assign valid_pkt = (tx_packet != PKT_NONE) && (tx_packet <= PKT_STALL);
    assign accept    = (state_q == ST_IDLE) && tx_start && valid_pkt;

    // Where the serialiser goes when the current byte has been fully sent
    always_comb begin
        nxt_state = state_q;
        nxt_byte  = new_byte;
        case (state_q)
            ST_SYNC: begin
                nxt_state = ST_PID;
                nxt_byte  = {~pid, pid};
            end
            ST_PID: begin
                if (!is_data) begin
                    nxt_state = ST_EOP;
                end else if (length != 7'd0) begin
                    nxt_state = ST_DATA;
                end else begin
                    nxt_state = ST_CRC_LO;
                    nxt_byte  = crc_out[7:0];
                end
            end
            ST_DATA: begin
                if (last_byte) begin
                    nxt_state = ST_CRC_LO;
                    nxt_byte  = crc_out[7:0];
                end
            end
            ST_CRC_LO: begin
                nxt_state = ST_CRC_HI;
                nxt_byte  = crc_out[15:8];
            end
            ST_CRC_HI: nxt_state = ST_EOP;
            default: ;
        endcase
    end

    assign emit_val  = byte_end ? nxt_byte[0] : shreg[bit_idx + 3'd1];
    assign enter_eop = byte_end && (nxt_state == ST_EOP);
    assign line_emit = boundary && serial && (stuff_now || !enter_eop);
    assign crc_en    = line_emit && !stuff_now &&
                       (byte_end ? (nxt_state == ST_DATA) : (state_q == ST_DATA));
    assign toggle    = stuff_now || !emit_val;
    assign nrzi_next = toggle ? ~nrzi_j : nrzi_j;

    usb_tx_crc16 u_crc (
        .clk     (clk),
        .rst     (rst),
        .clear   (accept),
        .bit_en  (crc_en),
        .bit_in  (emit_val),
        .crc_out (crc_out)
    );

    // Packet FSM, bit timer, stuffing, NRZI line and buffer fetch
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q            <= ST_IDLE;
            line_q             <= LINE_J;
            nrzi_j             <= 1'b1;
            clk_cnt            <= '0;
            bit_idx            <= '0;
            stuff_cnt          <= '0;
            shreg              <= '0;
            cap_pending        <= 1'b0;
            byte_cnt           <= '0;
            length             <= '0;
            pid                <= '0;
            is_data            <= 1'b0;
            get_tx_data        <= 1'b0;
            tx_transfer_active <= 1'b0;
            tx_error           <= 1'b0;
        end else begin
            get_tx_data <= 1'b0;
            tx_error    <= 1'b0;
            cap_pending <= get_tx_data;
            if (cap_pending) shreg <= tx_packet_data;
            if (state_q != ST_IDLE) clk_cnt <= boundary ? BIT_RELOAD : clk_cnt - CNT_W'(1);

            case (state_q)
                ST_IDLE: begin
                    if (tx_start && !valid_pkt) begin
                        tx_error <= 1'b1;
                    end else if (accept) begin
                        state_q            <= ST_SYNC;
                        tx_transfer_active <= 1'b1;
                        pid                <= pid_of(tx_packet);
                        is_data            <= (tx_packet == PKT_DATA0) || (tx_packet == PKT_DATA1);
                        length             <= (buffer_occupancy > MAX_LEN) ? MAX_LEN : buffer_occupancy;
                        shreg              <= SYNC_BYTE;
                        bit_idx            <= '0;
                        clk_cnt            <= BIT_RELOAD;
                        // First SYNC bit is a 0: the line toggles from J to K right away
                        stuff_cnt          <= '0;
                        nrzi_j             <= 1'b0;
                        line_q             <= LINE_K;
                    end
                end
                ST_EOP: begin
                    if (boundary) begin
                        if (bit_idx == 3'd0) begin
                            bit_idx <= 3'd1;
                        end else begin
                            state_q <= ST_IDLE_J;
                            bit_idx <= '0;
                            line_q  <= LINE_J;
                            nrzi_j  <= 1'b1;
                        end
                    end
                end
                ST_IDLE_J: begin
                    if (boundary) begin
                        state_q            <= ST_IDLE;
                        tx_transfer_active <= 1'b0;
                    end
                end
                default: begin
                    if (boundary) begin
                        if (line_emit) begin
                            line_q    <= nrzi_next ? LINE_J : LINE_K;
                            nrzi_j    <= nrzi_next;
                            stuff_cnt <= toggle ? 3'd0 : stuff_cnt + 3'd1;
                        end else begin
                            line_q <= LINE_SE0;
                        end
                        // A stuffed bit holds the serialiser where it is
                        if (!stuff_now) begin
                            if (!byte_end) begin
                                bit_idx <= bit_idx + 3'd1;
                                if ((bit_idx == 3'd6) && fetch_due) get_tx_data <= 1'b1;
                            end else begin
                                state_q  <= nxt_state;
                                bit_idx  <= '0;
                                shreg    <= nxt_byte;
                                byte_cnt <= (state_q == ST_DATA) ? byte_cnt + 7'd1 : 7'd0;
                            end
                        end
                    end
                end
            endcase
        end
    end

`ifdef USB_TX_PKT_CNT_EN
    // Count packets as the line returns to idle after the J bit
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_pkt_count <= '0;
        end else if ((state_q == ST_IDLE_J) && boundary) begin
            tx_pkt_count <= tx_pkt_count + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_usb_tx_packet_sender.sv
// tb/tb_usb_tx_packet_sender.sv - randomized self-checking bench for usb_tx_packet_sender
module tb_usb_tx_packet_sender;
    localparam int C      = 8;
    localparam int MAXREC = 8000;

    logic       clk = 1'b0;
    logic       rst;
    logic       tx_start;
    logic [2:0] tx_packet;
    logic [6:0] buffer_occupancy;
    logic [7:0] tx_packet_data = 8'h00;
    logic       get_tx_data;
    logic       dplus_out;
    logic       dminus_out;
    logic       tx_transfer_active;
    logic       tx_error;
`ifdef USB_TX_PKT_CNT_EN
    logic [7:0] tx_pkt_count;
`endif

    usb_tx_packet_sender #(.CLKS_PER_BIT(C), .MAX_PAYLOAD(64)) dut (
        .clk                (clk),
        .rst                (rst),
        .tx_start           (tx_start),
        .tx_packet          (tx_packet),
        .buffer_occupancy   (buffer_occupancy),
        .tx_packet_data     (tx_packet_data),
        .get_tx_data        (get_tx_data),
        .dplus_out          (dplus_out),
        .dminus_out         (dminus_out),
        .tx_transfer_active (tx_transfer_active),
        .tx_error           (tx_error)
`ifdef USB_TX_PKT_CNT_EN
        ,
        .tx_pkt_count       (tx_pkt_count)
`endif
    );

    always #5 clk = ~clk;

    logic [7:0] mem [0:127];
    int         rd_ptr = 0;
    logic [7:0] pid_tab [0:5] = '{8'h00, 8'hC3, 8'h4B, 8'hD2, 8'h5A, 8'h1E};

    // Registered-read buffer model: data follows the pop strobe by one cycle
    always @(posedge clk) begin
        if (!tx_transfer_active) begin
            rd_ptr <= 0;
        end else if (get_tx_data) begin
            tx_packet_data <= mem[rd_ptr[6:0]];
            rd_ptr         <= rd_ptr + 1;
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Byte-wise CRC-16/USB over mem[0..len-1], transmitted (inverted) value
    function automatic logic [15:0] usb_crc16(input int len);
        logic [15:0] c;
        c = 16'hFFFF;
        for (int k = 0; k < len; k++) begin
            c = c ^ {8'h00, mem[k]};
            for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
        end
        return ~c;
    endfunction

    logic [1:0] rec_line [MAXREC];
    bit         rec_act  [MAXREC];
    bit         rec_get  [MAXREC];

    task automatic run_packet(input int ptype, input int occ, input int inject_cyc, input string name);
        logic [7:0] bytes_q[$];
        logic [7:0] sync_b;
        logic [7:0] dbyte;
        logic [15:0] crc;
        logic [1:0] exp_line[$];
        logic [1:0] l;
        bit pre[$];
        bit post[$];
        bit dec[$];
        int premap[$];
        int exp_get[$];
        int got_get[$];
        int len, ones, nbits, ncyc, errs, act_n, nb;
        bit lvl, prev, cur, bv;

        len = (ptype <= 2) ? ((occ > 64) ? 64 : occ) : 0;
        bytes_q.push_back(pid_tab[ptype]);
        if (ptype <= 2) begin
            for (int k = 0; k < len; k++) bytes_q.push_back(mem[k]);
            crc = usb_crc16(len);
            bytes_q.push_back(crc[7:0]);
            bytes_q.push_back(crc[15:8]);
        end
        sync_b = 8'h80;
        for (int b = 0; b < 8; b++) pre.push_back(sync_b[b]);
        foreach (bytes_q[k]) begin
            dbyte = bytes_q[k];
            for (int b = 0; b < 8; b++) pre.push_back(dbyte[b]);
        end
        ones = 0;
        foreach (pre[i]) begin
            premap.push_back(post.size());
            post.push_back(pre[i]);
            if (pre[i]) begin
                ones++;
                if (ones == 6) begin
                    post.push_back(1'b0);
                    ones = 0;
                end
            end else begin
                ones = 0;
            end
        end
        // Pop for payload byte k comes at the start of bit 7 of the byte before it
        for (int k = 0; k < len; k++) exp_get.push_back(premap[8 + 8*k + 7] * C);
        lvl = 1'b1;
        foreach (post[i]) begin
            if (!post[i]) lvl = ~lvl;
            exp_line.push_back(lvl ? 2'b10 : 2'b01);
        end
        exp_line.push_back(2'b00);
        exp_line.push_back(2'b00);
        exp_line.push_back(2'b10);
        nbits = exp_line.size();
        ncyc  = nbits * C + 2 * C;

        @(negedge clk);
        tx_packet        = 3'(ptype);
        buffer_occupancy = 7'(occ);
        tx_start         = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        for (int i = 0; i < ncyc; i++) begin
            rec_line[i] = {dplus_out, dminus_out};
            rec_act[i]  = tx_transfer_active;
            rec_get[i]  = get_tx_data;
            tx_start    = (i == inject_cyc);
            if (i == inject_cyc) tx_packet = 3'd4;
            @(negedge clk);
        end
        tx_start = 1'b0;

        errs = 0;
        for (int i = 0; i < ncyc; i++)
            if (rec_line[i] !== ((i < nbits * C) ? exp_line[i / C] : 2'b10)) errs++;
        check({name, "_line"}, errs, 0);

        errs  = 0;
        act_n = 0;
        for (int i = 0; i < ncyc; i++) begin
            if (rec_act[i] !== (i < nbits * C)) errs++;
            if (rec_act[i]) act_n++;
            if (rec_get[i]) got_get.push_back(i);
        end
        check({name, "_active_shape"}, errs, 0);
        check({name, "_active_len"}, act_n, nbits * C);
        check({name, "_get_count"}, got_get.size(), len);
        errs = 0;
        foreach (exp_get[k]) if (k >= got_get.size() || got_get[k] != exp_get[k]) errs++;
        check({name, "_get_pos"}, errs, 0);

        // Independent receiver: mid-bit sampling, NRZI decode, de-stuff
        prev = 1'b1;
        ones = 0;
        for (int b = 0; b * C + C / 2 < ncyc; b++) begin
            l = rec_line[b * C + C / 2];
            if (l == 2'b00) break;
            cur  = (l == 2'b10);
            bv   = (cur == prev);
            prev = cur;
            if (ones == 6) begin
                ones = 0;
            end else begin
                dec.push_back(bv);
                ones = bv ? ones + 1 : 0;
            end
        end
        check({name, "_dec_bits"}, dec.size(), 8 + 8 * bytes_q.size());
        errs = 0;
        nb   = (dec.size() - 8) / 8;
        for (int k = 0; k < bytes_q.size(); k++) begin
            dbyte = 8'h00;
            if (k < nb) for (int b = 0; b < 8; b++) dbyte[b] = dec[8 + 8*k + b];
            if (dbyte !== bytes_q[k]) errs++;
        end
        check({name, "_dec_bytes"}, errs, 0);
    endtask

    initial begin
        rst              = 1'b1;
        tx_start         = 1'b0;
        tx_packet        = 3'd0;
        buffer_occupancy = 7'd0;
        for (int k = 0; k < 128; k++) mem[k] = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_dplus", dplus_out, 1);
        check("rst_dminus", dminus_out, 0);
        check("rst_active", tx_transfer_active, 0);
        check("rst_get", get_tx_data, 0);
        check("rst_err", tx_error, 0);
        rst = 1'b0;

        // ACK with a stray start request partway through
        run_packet(3, 0, 40, "ack");
        run_packet(1, 0, -1, "data0_zlp");
        mem[0] = 8'hFF;
        mem[1] = 8'h55;
        run_packet(2, 1, -1, "data1_ff");
        for (int k = 0; k < 64; k++) mem[k] = 8'(k);
        run_packet(1, 64, -1, "data0_inc64");

        foreach (pid_tab[p]) begin
            if (p == 0) begin
                for (int q = 0; q < 3; q++) begin
                    @(negedge clk);
                    tx_packet = (q == 0) ? 3'd0 : ((q == 1) ? 3'd6 : 3'd7);
                    tx_start  = 1'b1;
                    @(negedge clk);
                    tx_start = 1'b0;
                    check("inv_err_pulse", tx_error, 1);
                    check("inv_idle", {tx_transfer_active, dplus_out, dminus_out}, 3'b010);
                    @(negedge clk);
                    check("inv_err_clear", tx_error, 0);
                end
            end
        end

        for (int r = 0; r < 6; r++) begin
            for (int k = 0; k < 128; k++) mem[k] = 8'($urandom);
            run_packet($urandom_range(1, 5), $urandom_range(0, 100), -1, "rand");
        end

        // Reset in the middle of a data payload
        for (int k = 0; k < 64; k++) mem[k] = 8'($urandom);
        @(negedge clk);
        tx_packet        = 3'd1;
        buffer_occupancy = 7'd64;
        tx_start         = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        repeat (300) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_line", {dplus_out, dminus_out}, 2'b10);
        check("midrst_active", tx_transfer_active, 0);
        check("midrst_get", get_tx_data, 0);
        rst = 1'b0;
        run_packet(3, 0, -1, "ack_after_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
